// File: rtl/operand_issue_pkg.sv
// rtl/operand_issue_pkg.sv - shared types and constants for the operand issue stage
package operand_issue_pkg;

   localparam int DATA_W = 32;
   localparam int REG_W  = 5;
   localparam int OP_W   = 4;

   // ALU op encodings carried through this stage untouched
   localparam logic [OP_W-1:0] OP_ADD = 4'b0010;
   localparam logic [OP_W-1:0] OP_AND = 4'b0000;
   localparam logic [OP_W-1:0] OP_OR  = 4'b0001;
   localparam logic [OP_W-1:0] OP_SUB = 4'b0110;
   localparam logic [OP_W-1:0] OP_SLT = 4'b0111;

   // Buffer occupancy: nothing, main only, main plus skid
   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_TWO   = 2'd2
   } occ_e;

   // One held instruction; rs/rt are kept so the entry can keep snooping forwards
   typedef struct packed {
      logic [REG_W-1:0]  rs;
      logic [REG_W-1:0]  rt;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic [OP_W-1:0]   op;
      logic [REG_W-1:0]  rd;
      logic              we;
   } entry_t;

endpackage

// File: rtl/operand_issue_stage_fwd_sel.sv
// rtl/operand_issue_stage_fwd_sel.sv - per-operand forwarding compare and select
module operand_fwd_sel #(
   parameter int WIDTH = 32,
   parameter int REGW  = 5
) (
   input  logic [REGW-1:0]  src,
   input  logic [WIDTH-1:0] held,
   input  logic             fwd_ex_valid,
   input  logic [REGW-1:0]  fwd_ex_rd,
   input  logic [WIDTH-1:0] fwd_ex_data,
   input  logic             fwd_wb_valid,
   input  logic [REGW-1:0]  fwd_wb_rd,
   input  logic [WIDTH-1:0] fwd_wb_data,
   output logic [WIDTH-1:0] value
);

   // Register 0 reads zero; the younger EX/MEM result beats the WB result
   always_comb begin
      value = held;
      if (src == '0) begin
         value = '0;
      end else if (fwd_ex_valid && (fwd_ex_rd == src)) begin
         value = fwd_ex_data;
      end else if (fwd_wb_valid && (fwd_wb_rd == src)) begin
         value = fwd_wb_data;
      end
   end

endmodule

// File: rtl/operand_issue_stage.sv
// rtl/operand_issue_stage.sv - forwarding operand capture with 2-entry skid buffer ahead of the ALU
module operand_issue_stage
   import operand_issue_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int OPW   = 4,
   parameter int REGW  = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [REGW-1:0]  in_rs,
   input  logic [REGW-1:0]  in_rt,
   input  logic [WIDTH-1:0] in_rs_data,
   input  logic [WIDTH-1:0] in_rt_data,
   input  logic [OPW-1:0]   in_op,
   input  logic [REGW-1:0]  in_rd,
   input  logic             in_we,
   input  logic             flush,
   input  logic             fwd_ex_valid,
   input  logic [REGW-1:0]  fwd_ex_rd,
   input  logic [WIDTH-1:0] fwd_ex_data,
   input  logic             fwd_wb_valid,
   input  logic [REGW-1:0]  fwd_wb_rd,
   input  logic [WIDTH-1:0] fwd_wb_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_a,
   output logic [WIDTH-1:0] out_b,
   output logic [OPW-1:0]   out_op,
   output logic [REGW-1:0]  out_rd,
   output logic             out_we
);

   occ_e   state_q, state_d;
   entry_t main_q, main_d;
   entry_t skid_q, skid_d;
   logic   in_ready_q, in_ready_d;

   entry_t in_ent, main_fwd, skid_fwd;
   logic   acc_fire, rel_fire;

   logic [WIDTH-1:0] in_a_sel, in_b_sel;
   logic [WIDTH-1:0] main_a_sel, main_b_sel;
   logic [WIDTH-1:0] skid_a_sel, skid_b_sel;

   operand_fwd_sel #(.WIDTH(WIDTH), .REGW(REGW)) u_sel_in_a (
      .src(in_rs), .held(in_rs_data),
      .fwd_ex_valid(fwd_ex_valid), .fwd_ex_rd(fwd_ex_rd), .fwd_ex_data(fwd_ex_data),
      .fwd_wb_valid(fwd_wb_valid), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
      .value(in_a_sel)
   );
   operand_fwd_sel #(.WIDTH(WIDTH), .REGW(REGW)) u_sel_in_b (
      .src(in_rt), .held(in_rt_data),
      .fwd_ex_valid(fwd_ex_valid), .fwd_ex_rd(fwd_ex_rd), .fwd_ex_data(fwd_ex_data),
      .fwd_wb_valid(fwd_wb_valid), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
      .value(in_b_sel)
   );
   operand_fwd_sel #(.WIDTH(WIDTH), .REGW(REGW)) u_sel_main_a (
      .src(main_q.rs), .held(main_q.a),
      .fwd_ex_valid(fwd_ex_valid), .fwd_ex_rd(fwd_ex_rd), .fwd_ex_data(fwd_ex_data),
      .fwd_wb_valid(fwd_wb_valid), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
      .value(main_a_sel)
   );
   operand_fwd_sel #(.WIDTH(WIDTH), .REGW(REGW)) u_sel_main_b (
      .src(main_q.rt), .held(main_q.b),
      .fwd_ex_valid(fwd_ex_valid), .fwd_ex_rd(fwd_ex_rd), .fwd_ex_data(fwd_ex_data),
      .fwd_wb_valid(fwd_wb_valid), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
      .value(main_b_sel)
   );
   operand_fwd_sel #(.WIDTH(WIDTH), .REGW(REGW)) u_sel_skid_a (
      .src(skid_q.rs), .held(skid_q.a),
      .fwd_ex_valid(fwd_ex_valid), .fwd_ex_rd(fwd_ex_rd), .fwd_ex_data(fwd_ex_data),
      .fwd_wb_valid(fwd_wb_valid), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
      .value(skid_a_sel)
   );
   operand_fwd_sel #(.WIDTH(WIDTH), .REGW(REGW)) u_sel_skid_b (
      .src(skid_q.rt), .held(skid_q.b),
      .fwd_ex_valid(fwd_ex_valid), .fwd_ex_rd(fwd_ex_rd), .fwd_ex_data(fwd_ex_data),
      .fwd_wb_valid(fwd_wb_valid), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
      .value(skid_b_sel)
   );

   // Forwarded views of the incoming and both held entries
   always_comb begin
      in_ent    = '{rs: in_rs, rt: in_rt, a: in_a_sel, b: in_b_sel,
                    op: in_op, rd: in_rd, we: in_we};
      main_fwd   = main_q;
      main_fwd.a = main_a_sel;
      main_fwd.b = main_b_sel;
      skid_fwd   = skid_q;
      skid_fwd.a = skid_a_sel;
      skid_fwd.b = skid_b_sel;
   end

   // Occupancy transitions and entry movement; held entries always take their forwarded view
   always_comb begin
      acc_fire   = in_valid && in_ready_q && !flush;
      rel_fire   = (state_q != OCC_EMPTY) && out_ready;
      state_d    = state_q;
      main_d     = main_fwd;
      skid_d     = skid_fwd;
      case (state_q)
         OCC_EMPTY: begin
            if (acc_fire) begin
               main_d  = in_ent;
               state_d = OCC_ONE;
            end
         end
         OCC_ONE: begin
            if (acc_fire && rel_fire) begin
               main_d = in_ent;
            end else if (acc_fire) begin
               skid_d  = in_ent;
               state_d = OCC_TWO;
            end else if (rel_fire) begin
               state_d = OCC_EMPTY;
            end
         end
         OCC_TWO: begin
            if (rel_fire) begin
               main_d  = skid_fwd;
               state_d = OCC_ONE;
            end
         end
         default: state_d = OCC_EMPTY;
      endcase
      if (flush) begin
         state_d = OCC_EMPTY;
      end
      in_ready_d = (state_d != OCC_TWO);
   end

   // State, entries and registered in_ready
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= OCC_EMPTY;
         main_q     <= '0;
         skid_q     <= '0;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         main_q     <= main_d;
         skid_q     <= skid_d;
         in_ready_q <= in_ready_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = (state_q != OCC_EMPTY);
   assign out_a     = main_q.a;
   assign out_b     = main_q.b;
   assign out_op    = main_q.op;
   assign out_rd    = main_q.rd;
   assign out_we    = main_q.we;

endmodule
